// File: rtl/reqc_s_fifo_ctl.sv
// Pointer and flow-control stage for the 4-entry request-channel buffer RAM.
// Drives the RAM write port and a look-ahead read address; the RAM registers the read address.
module reqc_s_fifo_ctl #(
  parameter int DW       = 36,
  parameter int AW       = 2,
  parameter int AFULL_TH = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   count,
  output logic          almost_full,
  output logic          ovf_err,
  input  logic          err_clr,
  output logic          ram_wen,
  output logic [AW-1:0] ram_wadr,
  output logic [DW-1:0] ram_wdata,
  output logic [AW-1:0] ram_radr,
  input  logic [DW-1:0] ram_rdata
);

  localparam int          DEPTH     = 1 << AW;
  localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_AFULL = (AW+1)'(AFULL_TH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          ovf_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (cnt == CNT_FULL);
  assign empty = (cnt == '0);

  // flush wins over both transfers; a full FIFO never accepts, even while popping.
  assign push = in_valid & ~full & ~flush;
  assign pop  = ~empty & out_ready & ~flush;

  assign in_ready    = ~full;
  assign out_valid   = ~empty;
  assign count       = cnt;
  assign almost_full = (cnt >= CNT_AFULL);
  assign ovf_err     = ovf_q;

  assign ram_wen   = push;
  assign ram_wadr  = wr_ptr;
  assign ram_wdata = in_data;

  // The RAM read is async from its registered address, so out_data is the RAM output as-is.
  assign out_data = ram_rdata;

  // Look ahead by one entry on pop so the RAM already holds the next head after the edge.
  always_comb begin
    // NOTE: assign a default before any condition so no path leaves the output unassigned (no latch).
    ram_radr = rd_ptr + AW'(pop);
    if (flush) ram_radr = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky overflow-attempt flag; flush leaves it alone and err_clr beats a new set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ovf_q <= 1'b0;
    else if (err_clr)          ovf_q <= 1'b0;
    else if (in_valid && full) ovf_q <= 1'b1;
  end

endmodule

// File: tb/tb_reqc_s_fifo_ctl.sv
// Bench for reqc_s_fifo_ctl: a behavioural 4x36 RAM plus a queue-based reference model,
// driven by directed scenarios followed by a randomized phase.
module tb_reqc_s_fifo_ctl;

  localparam int DW = 36;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic          almost_full;
  logic          ovf_err;
  logic          err_clr;
  logic          ram_wen;
  logic [AW-1:0] ram_wadr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_radr;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  reqc_s_fifo_ctl #(.DW(DW), .AW(AW), .AFULL_TH(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(almost_full), .ovf_err(ovf_err), .err_clr(err_clr),
    .ram_wen(ram_wen), .ram_wadr(ram_wadr), .ram_wdata(ram_wdata),
    .ram_radr(ram_radr), .ram_rdata(ram_rdata)
  );

  // Buffer RAM: synchronous write, registered read address, asynchronous read.
  logic [DW-1:0] mem [4];
  logic [AW-1:0] radr_q;
  always @(posedge clk) begin
    if (ram_wen) mem[ram_wadr] <= ram_wdata;
    radr_q <= ram_radr;
  end
  assign ram_rdata = mem[radr_q];

  // Reference model: contents in order, sticky flag, and write/read slot indices.
  logic [DW-1:0] q[$];
  bit            m_ovf;
  int            widx;
  int            ridx;
  int            tests = 0;
  int            fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    widx  = 0;
    ridx  = 0;
  endtask

  // One clock cycle: drive after the falling edge, compare the model's view of the
  // combinational outputs, then advance the model across the rising edge.
  task automatic step(input bit iv, input logic [DW-1:0] d, input bit ordy,
                      input bit fl = 1'b0, input bit ec = 1'b0);
    bit exp_full, exp_push, exp_pop;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    err_clr   = ec;
    #1;
    exp_full = (q.size() == 4);
    exp_push = iv && !exp_full && !fl;
    exp_pop  = (q.size() != 0) && ordy && !fl;
    check("in_ready",    64'(in_ready),    64'(!exp_full));
    check("out_valid",   64'(out_valid),   64'(q.size() != 0));
    check("count",       64'(count),       64'(q.size()));
    check("almost_full", 64'(almost_full), 64'(q.size() >= 3));
    check("ovf_err",     64'(ovf_err),     64'(m_ovf));
    check("ram_wen",     64'(ram_wen),     64'(exp_push));
    if (exp_push) begin
      check("ram_wadr",  64'(ram_wadr),  64'(widx % 4));
      check("ram_wdata", 64'(ram_wdata), 64'(d));
    end
    check("ram_radr", 64'(ram_radr), fl ? 64'd0 : 64'((ridx + int'(exp_pop)) % 4));
    if (q.size() != 0) check("out_data", 64'(out_data), 64'(q[0]));
    @(posedge clk);
    if (ec)                m_ovf = 1'b0;
    else if (iv && exp_full) m_ovf = 1'b1;
    if (fl) begin
      q.delete();
      widx = 0;
      ridx = 0;
    end else begin
      if (exp_pop)  begin void'(q.pop_front()); ridx++; end
      if (exp_push) begin q.push_back(d); widx++; end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_count",    64'(count),       64'd0);
    check("rst_in_ready", 64'(in_ready),    64'd1);
    check("rst_out_valid",64'(out_valid),   64'd0);
    check("rst_afull",    64'(almost_full), 64'd0);
    check("rst_ovf",      64'(ovf_err),     64'd0);
    check("rst_wen",      64'(ram_wen),     64'd0);
    check("rst_radr",     64'(ram_radr),    64'd0);
    rst_n = 1'b1;

    // Fill to four without popping; head stays A0.
    for (int i = 0; i < 4; i++) step(1'b1, 36'hA0 + 36'(i), 1'b0);
    step(1'b0, '0, 1'b0);
    check("t1_count_full", 64'(count),    64'd4);
    check("t1_head_a0",    64'(out_data), 64'hA0);

    // Push attempts while full set the sticky flag; err_clr drops it.
    step(1'b1, 36'hBAD, 1'b0);
    step(1'b1, 36'hBAD, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Full with simultaneous pop and push: no pass-through.
    step(1'b1, 36'hC0FFEE, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // Empty: push B with out_ready high, then it drains.
    step(1'b1, 36'hB, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // Streaming 0..19: count holds at one, pointers wrap continuously.
    for (int i = 0; i < 20; i++) step(1'b1, 36'(i), 1'b1);
    step(1'b0, '0, 1'b1);

    // Three entries, out_ready toggling while pushing.
    for (int i = 0; i < 3; i++) step(1'b1, 36'h300 + 36'(i), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 36'h310 + 36'(i), i[0] == 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

    // Two entries then flush with in_valid high; next push C reads back.
    step(1'b1, 36'h61, 1'b0);
    step(1'b1, 36'h62, 1'b0);
    step(1'b1, 36'h63, 1'b1, 1'b1);
    step(1'b1, 36'hC, 1'b0);
    step(1'b0, '0, 1'b0);
    check("t6_readback_c", 64'(out_data), 64'hC);
    step(1'b0, '0, 1'b1);

    // Reset asserted mid-transfer clears state immediately.
    step(1'b1, 36'h71, 1'b0);
    step(1'b1, 36'h72, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_count",    64'(count),     64'd0);
    check("mid_rst_out_valid",64'(out_valid), 64'd0);
    check("mid_rst_radr",     64'(ram_radr),  64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized phase against the model.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, {4'($urandom), 32'($urandom)},
           $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
